// File: rtl/piano_pkg.sv
// Shared constants, colours and renderer state encoding for the piano-tiles video path.
package piano_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int LANE_W    = 40;
    localparam int TILE_H    = 20;
    localparam int NUM_LANES = 4;

    localparam logic [2:0] COL_TILE = 3'b111;
    localparam logic [2:0] COL_BG   = 3'b000;
    localparam logic [2:0] COL_OVER = 3'b100;
    localparam logic [2:0] COL_HIT  = 3'b001;

    localparam int HIT_TOP = 90;
    localparam int HIT_BOT = 119;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } rstate_e;

endpackage

// File: rtl/pixel_scan_counter.sv
// Nested lane/row/col scan counter; col is innermost. last flags the final pixel of a frame.
module pixel_scan_counter
    import piano_pkg::*;
#(
    parameter int COL_W = $clog2(LANE_W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             adv_i,
    output logic [1:0]       lane_o,
    output logic [6:0]       row_o,
    output logic [COL_W-1:0] col_o,
    output logic             last_o
);

    logic [1:0]       lane_q, lane_d;
    logic [6:0]       row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        lane_d = lane_q;
        row_d  = row_q;
        col_d  = col_q;
        if (clear_i) begin
            lane_d = '0;
            row_d  = '0;
            col_d  = '0;
        end else if (adv_i) begin
            if (col_q == COL_W'(LANE_W - 1)) begin
                col_d = '0;
                if (row_q == 7'(SCREEN_H - 1)) begin
                    row_d  = '0;
                    lane_d = lane_q + 2'd1;
                end else begin
                    row_d = row_q + 7'd1;
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lane_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            lane_q <= lane_d;
            row_q  <= row_d;
            col_q  <= col_d;
        end
    end

    assign lane_o = lane_q;
    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (lane_q == 2'(NUM_LANES - 1)) && (row_q == 7'(SCREEN_H - 1)) &&
                    (col_q == COL_W'(LANE_W - 1));

endmodule

// File: rtl/tile_renderer.sv
// Draws one frame of the four tile lanes into the VGA adapter, one pixel per cycle.
// Optional macro TILE_RENDERER_HIT_ZONE_EN paints non-tile pixels of the hit rows HIT_COLOUR.
module tile_renderer
    import piano_pkg::*;
#(
    parameter logic [2:0] TILE_COLOUR = COL_TILE,
    parameter logic [2:0] BG_COLOUR   = COL_BG,
    parameter logic [2:0] OVER_COLOUR = COL_OVER,
    parameter logic [2:0] HIT_COLOUR  = COL_HIT,
    parameter int         HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       gamedone,
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic [7:0] x3,
    input  logic [7:0] x4,
    input  logic [6:0] y1,
    input  logic [6:0] y2,
    input  logic [6:0] y3,
    input  logic [6:0] y4,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done,
    output logic       busy
);

    localparam int COL_W = $clog2(LANE_W);
    localparam int HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    rstate_e         state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [3:0][7:0] xl_q;
    logic [3:0][6:0] yl_q;
    logic            over_q;

    logic             scan_clr, scan_adv, scan_last;
    logic [1:0]       lane;
    logic [6:0]       row;
    logic [COL_W-1:0] col;

    pixel_scan_counter #(.COL_W(COL_W)) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (scan_clr),
        .adv_i   (scan_adv),
        .lane_o  (lane),
        .row_o   (row),
        .col_o   (col),
        .last_o  (scan_last)
    );

    // Frame parameters are frozen at the start edge so the game datapath may update mid-frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            xl_q   <= '0;
            yl_q   <= '0;
            over_q <= 1'b0;
        end else if (state_q == IDLE && enable) begin
            xl_q   <= {x4, x3, x2, x1};
            yl_q   <= {y4, y3, y2, y1};
            over_q <= gamedone;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        scan_clr = 1'b0;
        scan_adv = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    scan_clr = 1'b1;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                scan_adv = 1'b1;
                if (scan_last) state_d = DONE;
            end
            DONE: begin
                hold_d  = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = IDLE;
                else                                hold_d  = hold_q + HW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Tile span is compared at 8 bits so a tile near the bottom cannot wrap back to the top.
    logic [7:0] row8, top8;
    logic       in_tile;
    logic [2:0] pix_col;

    always_comb begin
        row8    = {1'b0, row};
        top8    = {1'b0, yl_q[lane]};
        in_tile = (row8 >= top8) && (row8 < top8 + 8'(TILE_H));
        if (over_q)       pix_col = OVER_COLOUR;
        else if (in_tile) pix_col = TILE_COLOUR;
`ifdef TILE_RENDERER_HIT_ZONE_EN
        else if (row >= 7'(HIT_TOP) && row <= 7'(HIT_BOT)) pix_col = HIT_COLOUR;
`endif
        else              pix_col = BG_COLOUR;
    end

    always_comb begin
        x_out  = '0;
        y_out  = '0;
        colour = '0;
        plot   = 1'b0;
        done   = 1'b0;
        busy   = 1'b0;
        if (state_q == DRAW) begin
            plot   = 1'b1;
            busy   = 1'b1;
            x_out  = xl_q[lane] + 8'(col);
            y_out  = row;
            colour = pix_col;
        end
        if (state_q == DONE) done = 1'b1;
    end

endmodule

// File: doc/tile_renderer.md
Name: tile_renderer

Overview:
- Draws one frame of the four falling tile lanes into the VGA adapter pixel interface. It is the drawing end of the enable/done handshake driven by the game state machine.
- On `enable`, it latches the lane x origins and tile y positions, then scans every pixel of every lane. Each pixel is coloured as tile, background or game-over fill.
- After the last pixel it pulses `done`, which lets the game state machine move to its update state.
- It sits between the game state datapath and the vga_adapter.

Parameters:
- SCREEN_H, 120, visible rows; row index 0..SCREEN_H-1.
- LANE_W, 40, lane width in pixels.
- TILE_H, 20, tile height in rows.
- TILE_COLOUR, 3'b111, tile pixel colour.
- BG_COLOUR, 3'b000, background colour.
- OVER_COLOUR, 3'b100, fill colour when game over.
- HOLD_CYCLES, 2, post-done cycles during which enable is ignored.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- enable  in  1  level request to draw a frame
- gamedone  in  1  game-over flag, sampled at frame start
- x1, x2, x3, x4  in  8 each  lane left-edge x origins
- y1, y2, y3, y4  in  7 each  tile top rows
- x_out  out  8  pixel x to vga_adapter
- y_out  out  7  pixel y to vga_adapter
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- done  out  1  one-cycle frame-complete pulse
- busy  out  1  high while in DRAW

Behaviour:
- Clocking: one clock, `clk`. Reset is synchronous and active-low on `reset_n`.
- Reset: state IDLE; x_out=0, y_out=0, colour=0, plot=0, done=0, busy=0; all counters 0.
- Reset mid-frame: the next cycle must show plot=0 and busy=0, and the partial frame is abandoned.
- States:
  - IDLE: if enable=1 at a clock edge, latch x1..x4, y1..y4 and gamedone, clear counters, and go to DRAW.
  - DRAW: emit one pixel per cycle with plot=1. On the last pixel go to DONE.
  - DONE: assert done=1 for exactly one cycle with plot=0, then go to HOLD.
  - HOLD: stay HOLD_CYCLES cycles with plot=0, ignoring enable, then go to IDLE. This gives the state machine time to update y positions while enable may stay high.
- Scan order: lane 0..3 outer, row 0..SCREEN_H-1 middle, col 0..LANE_W-1 inner.
  - x_out = latched x_lane + col (8-bit, no wrap expected).
  - y_out = row.
- Frame length:
  - 4*LANE_W*SCREEN_H pixels (19200 at defaults).
  - The first plot is in the cycle after the enable-sampling edge.
  - done is in the cycle after the last plot.
- Colour rule, in priority order:
  1. If the latched gamedone=1, every pixel is OVER_COLOUR.
  2. Else, if y_lane <= row < y_lane+TILE_H, the pixel is TILE_COLOUR. The sum is computed at 8 bits, so there is no 7-bit wrap.
  3. Else the pixel is BG_COLOUR.
- Clipping: tile rows >= SCREEN_H are never emitted; y_out never exceeds SCREEN_H-1.
- Input changes: changes to the inputs during DRAW have no effect, because only the latched copies are used.
- Enable timing: enable deasserting during DRAW does not abort the frame.

Optional Feature:
- Macro: `TILE_RENDERER_HIT_ZONE_EN`.
- Defined: non-tile pixels in rows HIT_TOP..HIT_BOT (90..119) are drawn HIT_COLOUR (3'b001). Tile colour and game-over fill still take priority over the zone.
- Undefined: no zone; non-tile pixels are BG_COLOUR.
- Frame timing is identical in both builds.

Decomposition:
- Package piano_pkg holds:
  - SCREEN_W=160, SCREEN_H=120, LANE_W, TILE_H
  - colour constants TILE/BG/OVER/HIT
  - HIT_TOP=90, HIT_BOT=119
  - renderer state enum {IDLE, DRAW, DONE, HOLD}
- One sub-module, pixel_scan_counter: nested lane/row/col counters with clear, advance and a `last` flag.

Test Plan:
- Reset check: assert reset_n=0 for 3 cycles -> plot=0, done=0, busy=0, x_out=0, y_out=0, colour=0.
- Default frame: enable=1, x=0/40/80/120, y=1/16/66/88, gamedone=0 -> exactly 19200 plot cycles, then done high for exactly 1 cycle. Pixel colours:
  - (0,1) = 111 and (0,0) = 000
  - (40,35) = 111 and (40,36) = 000
  - (159,107) = 111
- Clipping: y4=120, y1=110 -> no y_out >= 120; lane 3 is all 000; lane 0 rows 110..119 are 111.
- Game over: gamedone=1 at frame start -> all 19200 pixels are 100. Dropping gamedone mid-frame has no effect.
- Back-to-back frames: enable held high throughout; y1 changes from 1 to 2 during HOLD -> done, then 2 cycles with plot=0, then a new frame begins showing (0,1)=000 and (0,21)=111.
- Reset mid-frame: reset_n=0 at pixel 5000 -> next cycle plot=0, busy=0. A later enable restarts at (x1,0) with a full 19200-pixel count.
- Hit zone (run with `TILE_RENDERER_HIT_ZONE_EN` defined): y2=16 -> (50,95) = 001 and (50,16) = 111. With the macro undefined, (50,95) = 000.
